// File: rtl/cpu_pkg.sv
// Shared definitions for the CPU control path.
// Holds the opcode map (IR[31:27]), the control FSM state encoding and the
// instruction-class enum produced by cu_decode and consumed by control_unit.
// Opcode 10100 (jal) is reserved and decodes as illegal.
package cpu_pkg;

  typedef logic [4:0] op_t;

  localparam op_t OpLd     = 5'b00000;
  localparam op_t OpLdi    = 5'b00001;
  localparam op_t OpSt     = 5'b00010;
  localparam op_t OpAdd    = 5'b00011;
  localparam op_t OpSub    = 5'b00100;
  localparam op_t OpAnd    = 5'b00101;
  localparam op_t OpOr     = 5'b00110;
  localparam op_t OpShr    = 5'b00111;
  localparam op_t OpShl    = 5'b01000;
  localparam op_t OpRor    = 5'b01001;
  localparam op_t OpRol    = 5'b01010;
  localparam op_t OpAddi   = 5'b01011;
  localparam op_t OpAndi   = 5'b01100;
  localparam op_t OpOri    = 5'b01101;
  localparam op_t OpMul    = 5'b01110;
  localparam op_t OpDiv    = 5'b01111;
  localparam op_t OpNeg    = 5'b10000;
  localparam op_t OpNot    = 5'b10001;
  localparam op_t OpBranch = 5'b10010;
  localparam op_t OpJr     = 5'b10011;
  localparam op_t OpIn     = 5'b10101;
  localparam op_t OpOut    = 5'b10110;
  localparam op_t OpMfhi   = 5'b10111;
  localparam op_t OpMflo   = 5'b11000;
  localparam op_t OpNop    = 5'b11001;
  localparam op_t OpHalt   = 5'b11010;

  typedef enum logic [3:0] {
    StReset,
    StT0,
    StT1,
    StT2,
    StT3,
    StT4,
    StT5,
    StT6,
    StT7,
    StHalt
  } state_e;

  typedef enum logic [3:0] {
    ClsAlu,     // reg-reg ALU
    ClsImm,     // addi/andi/ori
    ClsLd,
    ClsLdi,
    ClsSt,
    ClsMulDiv,
    ClsMfhi,
    ClsMflo,
    ClsIn,
    ClsOut,
    ClsJr,
    ClsBranch,
    ClsNop,
    ClsHalt     // halt opcode and anything illegal
  } instr_cls_e;

endpackage

// File: rtl/cu_decode.sv
// Combinational opcode-to-class decoder for the control unit.
// Ports:
//   op      - opcode field IR[31:27]
//   cls     - instruction class (ClsHalt for halt and illegal opcodes)
//   illegal - high for any opcode the unit does not implement
// Macro CU_MULDIV_EN: when undefined, mul/div/mfhi/mflo decode as illegal.
module cu_decode
  import cpu_pkg::*;
(
  input  logic [4:0] op,
  output instr_cls_e cls,
  output logic       illegal
);

  always_comb begin
    cls     = ClsHalt;
    illegal = 1'b0;
    case (op)
      OpAdd, OpSub, OpAnd, OpOr, OpShr, OpShl, OpRor, OpRol, OpNeg, OpNot: cls = ClsAlu;
      OpAddi, OpAndi, OpOri: cls = ClsImm;
      OpLd:     cls = ClsLd;
      OpLdi:    cls = ClsLdi;
      OpSt:     cls = ClsSt;
      OpIn:     cls = ClsIn;
      OpOut:    cls = ClsOut;
      OpJr:     cls = ClsJr;
      OpBranch: cls = ClsBranch;
      OpNop:    cls = ClsNop;
      OpHalt:   cls = ClsHalt;
`ifdef CU_MULDIV_EN
      OpMul, OpDiv: cls = ClsMulDiv;
      OpMfhi:       cls = ClsMfhi;
      OpMflo:       cls = ClsMflo;
`else
      OpMul, OpDiv, OpMfhi, OpMflo: illegal = 1'b1;
`endif
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/control_unit.sv
// Moore-style control FSM for a bus-based 32-bit CPU datapath.
// Sequence: RESET -> T0..T2 (fetch) -> T3..T7 (execute, class dependent) -> T0,
// or HALT on halt/illegal opcode or a pending Stop request.
// Ports:
//   Clock, clear      - clock and synchronous active-high reset
//   IR, CON_FF, Stop  - instruction register, branch flag, halt request
//   Run               - high unless halted
//   Gra..BAout        - register select and strobes
//   PCout..Cout       - bus drivers (at most one per state)
//   PCin..Outportin   - register loads
//   Read/Write/IncPC  - memory and PC controls
//   opcode            - ALU operation during ALU steps, otherwise 0
// Macro CU_MULDIV_EN enables mul/div/mfhi/mflo; undefined keeps HI/LO strobes at 0.
module control_unit
  import cpu_pkg::*;
#(
  parameter int unsigned OPW = 5
) (
  input  logic           Clock,
  input  logic           clear,
  input  logic [31:0]    IR,
  input  logic           CON_FF,
  input  logic           Stop,
  output logic           Run,
  output logic           Gra,
  output logic           Grb,
  output logic           Grc,
  output logic           Rin,
  output logic           Rout,
  output logic           BAout,
  output logic           PCout,
  output logic           MDRout,
  output logic           Zhighout,
  output logic           Zlowout,
  output logic           HIout,
  output logic           LOout,
  output logic           Inportout,
  output logic           Cout,
  output logic           PCin,
  output logic           IRin,
  output logic           MARin,
  output logic           MDRin,
  output logic           Yin,
  output logic           Zin,
  output logic           HIin,
  output logic           LOin,
  output logic           CONin,
  output logic           Outportin,
  output logic           Read,
  output logic           Write,
  output logic           IncPC,
  output logic [OPW-1:0] opcode
);

  state_e     state_q, state_d;
  logic       stop_q;
  op_t        op_q;
  op_t        cur_op;
  instr_cls_e cls;
  logic       illegal;
  logic       last;
  logic       unused_ir;

  assign unused_ir = ^IR[26:0];

  // IR is loaded on the T2 edge, so it is read live in T3 and held from then on.
  assign cur_op = (state_q == StT3) ? IR[31:27] : op_q;

  cu_decode u_decode (
    .op      (cur_op),
    .cls     (cls),
    .illegal (illegal)
  );

  always_ff @(posedge Clock) begin
    if (clear) begin
      state_q <= StReset;
      stop_q  <= 1'b0;
      op_q    <= OpNop;
    end else begin
      state_q <= state_d;
      stop_q  <= stop_q | Stop;
      if (state_q == StT3) begin
        op_q <= IR[31:27];
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    last      = 1'b0;
    Run       = 1'b1;
    Gra       = 1'b0;
    Grb       = 1'b0;
    Grc       = 1'b0;
    Rin       = 1'b0;
    Rout      = 1'b0;
    BAout     = 1'b0;
    PCout     = 1'b0;
    MDRout    = 1'b0;
    Zhighout  = 1'b0;
    Zlowout   = 1'b0;
    HIout     = 1'b0;
    LOout     = 1'b0;
    Inportout = 1'b0;
    Cout      = 1'b0;
    PCin      = 1'b0;
    IRin      = 1'b0;
    MARin     = 1'b0;
    MDRin     = 1'b0;
    Yin       = 1'b0;
    Zin       = 1'b0;
    HIin      = 1'b0;
    LOin      = 1'b0;
    CONin     = 1'b0;
    Outportin = 1'b0;
    Read      = 1'b0;
    Write     = 1'b0;
    IncPC     = 1'b0;
    opcode    = '0;

    case (state_q)
      StReset: last = 1'b1;
      StT0: begin
        PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1; Zin = 1'b1;
        state_d = StT1;
      end
      StT1: begin
        Zlowout = 1'b1; PCin = 1'b1; Read = 1'b1; MDRin = 1'b1;
        state_d = StT2;
      end
      StT2: begin
        MDRout = 1'b1; IRin = 1'b1;
        state_d = StT3;
      end
      StT3: begin
        if (illegal) begin
          state_d = StHalt;
        end else begin
          case (cls)
            ClsAlu, ClsImm: begin
              Grb = 1'b1; Rout = 1'b1; Yin = 1'b1; state_d = StT4;
            end
            ClsLd, ClsLdi, ClsSt: begin
              Grb = 1'b1; BAout = 1'b1; Yin = 1'b1; state_d = StT4;
            end
            ClsMulDiv: begin
              Gra = 1'b1; Rout = 1'b1; Yin = 1'b1; state_d = StT4;
            end
            ClsMfhi:   begin Gra = 1'b1; Rin = 1'b1; HIout = 1'b1; last = 1'b1; end
            ClsMflo:   begin Gra = 1'b1; Rin = 1'b1; LOout = 1'b1; last = 1'b1; end
            ClsIn:     begin Gra = 1'b1; Rin = 1'b1; Inportout = 1'b1; last = 1'b1; end
            ClsOut:    begin Gra = 1'b1; Rout = 1'b1; Outportin = 1'b1; last = 1'b1; end
            ClsJr:     begin Gra = 1'b1; Rout = 1'b1; PCin = 1'b1; last = 1'b1; end
            ClsBranch: begin
              Gra = 1'b1; Rout = 1'b1; CONin = 1'b1; state_d = StT4;
            end
            ClsNop:    last = 1'b1;
            default:   state_d = StHalt;
          endcase
        end
      end
      StT4: begin
        case (cls)
          ClsAlu: begin
            Grc = 1'b1; Rout = 1'b1; Zin = 1'b1; opcode = OPW'(cur_op); state_d = StT5;
          end
          ClsImm: begin
            Cout = 1'b1; Zin = 1'b1; opcode = OPW'(cur_op); state_d = StT5;
          end
          ClsLd, ClsLdi, ClsSt: begin
            Cout = 1'b1; Zin = 1'b1; opcode = OPW'(OpAdd); state_d = StT5;
          end
          ClsMulDiv: begin
            Grb = 1'b1; Rout = 1'b1; Zin = 1'b1; opcode = OPW'(cur_op); state_d = StT5;
          end
          ClsBranch: begin
            PCout = 1'b1; Yin = 1'b1; state_d = StT5;
          end
          default: state_d = StHalt;
        endcase
      end
      StT5: begin
        case (cls)
          ClsAlu, ClsImm, ClsLdi: begin
            Zlowout = 1'b1; Gra = 1'b1; Rin = 1'b1; last = 1'b1;
          end
          ClsLd, ClsSt: begin
            Zlowout = 1'b1; MARin = 1'b1; state_d = StT6;
          end
          ClsMulDiv: begin
            Zlowout = 1'b1; LOin = 1'b1; state_d = StT6;
          end
          ClsBranch: begin
            Cout = 1'b1; Zin = 1'b1; opcode = OPW'(OpAdd); state_d = StT6;
          end
          default: state_d = StHalt;
        endcase
      end
      StT6: begin
        case (cls)
          ClsLd:     begin Read = 1'b1; MDRin = 1'b1; state_d = StT7; end
          ClsSt:     begin Gra = 1'b1; Rout = 1'b1; MDRin = 1'b1; state_d = StT7; end
          ClsMulDiv: begin Zhighout = 1'b1; HIin = 1'b1; last = 1'b1; end
          ClsBranch: begin Zlowout = 1'b1; PCin = CON_FF; last = 1'b1; end
          default:   state_d = StHalt;
        endcase
      end
      StT7: begin
        case (cls)
          ClsLd:   begin MDRout = 1'b1; Gra = 1'b1; Rin = 1'b1; last = 1'b1; end
          ClsSt:   begin Write = 1'b1; last = 1'b1; end
          default: state_d = StHalt;
        endcase
      end
      StHalt: begin
        Run     = 1'b0;
        state_d = StHalt;
      end
      default: state_d = StHalt;
    endcase

    // A Stop seen on this edge or any earlier one diverts the return to fetch.
    if (last) begin
      state_d = (stop_q | Stop) ? StHalt : StT0;
    end

`ifndef CU_MULDIV_EN
    HIin  = 1'b0;
    LOin  = 1'b0;
    HIout = 1'b0;
    LOout = 1'b0;
`endif
  end

endmodule
